// File: rtl/ssp_rx_deserializer_fifo.sv
// ---------------------------------------------------------------------------
// ssp_rx_deserializer_fifo
//
// SSP receive path. It deserialises SSPRXD frames of 4..MAX_W bits, MSB-first
// or LSB-first, framed by SSPFSSIN. Completed words go into a DEPTH-entry
// first-word-fall-through FIFO that reports level, full and a sticky overrun.
//
// Ports
//   SSPCLKIN        sole clock, rising edge
//   CLEAR           asynchronous active-high reset
//   SSPRXD          serial data, sampled every edge while shifting
//   SSPFSSIN        frame sync; high at an idle edge starts a frame
//   RX_ENABLE       allows new frames to start
//   DSS[3:0]        frame length minus one (clamped to 3..MAX_W-1)
//   LSB_FIRST       bit order of the frame: 0 MSB first, 1 LSB first
//   RX_RD           pop strobe
//   OVR_CLR         clears RX_OVERRUN (a simultaneous set wins)
//   RxData          FIFO head word, zero when empty
//   RX_NOT_EMPTY    FIFO holds at least one word
//   RX_FULL         FIFO holds DEPTH words
//   RX_LEVEL        word count 0..DEPTH
//   RX_OVERRUN      sticky: a word was dropped on a full FIFO
//   receive_signal  one-cycle pulse after each completed frame
//   rx_state_dbg    current deserialiser state (0 idle, 1 shifting)
//
// Read handshake: RxData is valid whenever RX_NOT_EMPTY is 1. The reader
// consumes the head word by holding RX_RD high across one rising edge; a pop
// takes effect only if RX_NOT_EMPTY was 1 at that edge, otherwise it is
// ignored. There is no back-pressure towards the serial side: a word that
// completes while the FIFO is full and not being popped is dropped.
// ---------------------------------------------------------------------------
module ssp_rx_deserializer_fifo #(
  parameter int MAX_W = 16,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic               SSPCLKIN,
  input  logic               CLEAR,
  input  logic               SSPRXD,
  input  logic               SSPFSSIN,
  input  logic               RX_ENABLE,
  input  logic [3:0]         DSS,
  input  logic               LSB_FIRST,
  input  logic               RX_RD,
  input  logic               OVR_CLR,
  output logic [MAX_W-1:0]   RxData,
  output logic               RX_NOT_EMPTY,
  output logic               RX_FULL,
  output logic [PTR_W:0]     RX_LEVEL,
  output logic               RX_OVERRUN,
  output logic               receive_signal,
  output logic               rx_state_dbg
);

  // The counter must hold any DSS value as well as MAX_W-1.
  localparam int CNT_W = (MAX_W > 16) ? $clog2(MAX_W) : 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       len_m1_q, len_m1_d;
  logic                   lsb_q, lsb_d;
  logic [MAX_W-1:0]       shift_q, shift_d;

  logic [MAX_W-1:0]       mem_q [DEPTH];
  logic [MAX_W-1:0]       mem_d [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]         level_q, level_d;
  logic                   ovr_q, ovr_d;
  logic                   rx_sig_q, rx_sig_d;

  logic [CNT_W-1:0]       len_m1_new;
  logic [CNT_W-1:0]       bit_pos;
  logic [MAX_W-1:0]       word_now;
  logic                   frame_done;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  logic                   push_ok;
  logic                   push_drop;

  // Frame length minus one from DSS, clamped to the supported range.
  always_comb begin
    len_m1_new = CNT_W'(DSS);
    if (DSS < 4'd3) begin
      len_m1_new = CNT_W'(3);
    end else if (32'(DSS) > 32'(MAX_W - 1)) begin
      len_m1_new = CNT_W'(MAX_W - 1);
    end
  end

  // The counter runs len-1 down to 0, so MSB-first bits land at the counter
  // value and LSB-first bits land at its mirror image within the frame.
  always_comb begin
    bit_pos = lsb_q ? (len_m1_q - cnt_q) : cnt_q;
  end

  // Shift register with the bit of the current edge merged in; on the last
  // bit this is the finished word.
  always_comb begin
    word_now = shift_q | (MAX_W'(SSPRXD) << bit_pos);
  end

  // Deserialiser next state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_m1_d   = len_m1_q;
    lsb_d      = lsb_q;
    shift_d    = shift_q;
    frame_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The data bit at the start edge is not part of the frame.
        if (SSPFSSIN && RX_ENABLE) begin
          state_d  = ST_SHIFT;
          cnt_d    = len_m1_new;
          len_m1_d = len_m1_new;
          lsb_d    = LSB_FIRST;
          shift_d  = '0;
        end
      end
      ST_SHIFT: begin
        shift_d = word_now;
        if (cnt_q == '0) begin
          frame_done = 1'b1;
          shift_d    = '0;
          if (SSPFSSIN && RX_ENABLE) begin
            // Zero-gap back-to-back frame: re-latch length and order now.
            cnt_d    = len_m1_new;
            len_m1_d = len_m1_new;
            lsb_d    = LSB_FIRST;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO control. When full, a push is still accepted if the head is being
  // popped at the same edge; the write then reuses the slot just vacated.
  always_comb begin
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == (PTR_W+1)'(DEPTH));
    pop        = RX_RD && !fifo_empty;
    push_ok    = frame_done && (!fifo_full || pop);
    push_drop  = frame_done && fifo_full && !pop;

    mem_d = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = word_now;
    end

    wr_ptr_d = push_ok ? (wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop     ? (rd_ptr_q + 1'b1) : rd_ptr_q;

    level_d = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // Set has priority over clear.
    ovr_d = ovr_q;
    if (push_drop) begin
      ovr_d = 1'b1;
    end else if (OVR_CLR) begin
      ovr_d = 1'b0;
    end

    rx_sig_d = frame_done;
  end

  always_ff @(posedge SSPCLKIN or posedge CLEAR) begin
    if (CLEAR) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      len_m1_q <= '0;
      lsb_q    <= 1'b0;
      shift_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovr_q    <= 1'b0;
      rx_sig_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_m1_q <= len_m1_d;
      lsb_q    <= lsb_d;
      shift_q  <= shift_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovr_q    <= ovr_d;
      rx_sig_q <= rx_sig_d;
    end
  end

  always_comb begin
    RxData         = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
    RX_NOT_EMPTY   = (level_q != '0);
    RX_FULL        = (level_q == (PTR_W+1)'(DEPTH));
    RX_LEVEL       = level_q;
    RX_OVERRUN     = ovr_q;
    receive_signal = rx_sig_q;
    rx_state_dbg   = state_q;
  end

endmodule

// File: doc/ssp_rx_deserializer_fifo.md
Name: ssp_rx_deserializer_fifo

Overview:
Next-generation SSP receive path. It deserialises SSPRXD frames of runtime-selectable length (4..MAX_W bits) in MSB-first or LSB-first order, framed by SSPFSSIN. Completed words are pushed into a DEPTH-entry first-word-fall-through receive FIFO with level, full and sticky-overrun status. It sits between the SSP pin interface and the bus-side register block, and replaces the fixed-width single-register receiver.

Parameters:
MAX_W, 16, maximum frame width in bits; also the RxData width; must be >= 4.
DEPTH, 4, FIFO entries; must be a power of two and >= 2.
PTR_W, 2, log2(DEPTH); FIFO pointer width.

Ports:
SSPCLKIN  in  1  sole clock; all state updates on its rising edge.
CLEAR  in  1  asynchronous, active-high reset.
SSPRXD  in  1  serial receive data, sampled on each rising edge while shifting.
SSPFSSIN  in  1  frame sync; high at an edge starts or continues a frame.
RX_ENABLE  in  1  1 allows new frames to start.
DSS  in  4  frame length minus 1; valid range 3..MAX_W-1.
LSB_FIRST  in  1  0 = MSB first, 1 = LSB first.
RX_RD  in  1  pop strobe; one word per asserted cycle.
OVR_CLR  in  1  clears RX_OVERRUN.
RxData  out  MAX_W  FIFO head word, right-justified and zero-extended.
RX_NOT_EMPTY  out  1  FIFO holds at least 1 word.
RX_FULL  out  1  FIFO holds DEPTH words.
RX_LEVEL  out  PTR_W+1  word count, 0..DEPTH.
RX_OVERRUN  out  1  sticky flag: a word was dropped because the FIFO was full.
receive_signal  out  1  one-cycle pulse per completed frame.

Behaviour:
- Reset (CLEAR=1, async):
  - state IDLE; bit counter, shift register, pointers and RX_LEVEL all 0.
  - RX_OVERRUN=0, receive_signal=0, RX_NOT_EMPTY=0, RX_FULL=0, RxData=0.
  - Assertion mid-frame discards the partial frame and the FIFO contents.
- Frame length: len = DSS+1, clamped to 4 when DSS<3 and to MAX_W when DSS>MAX_W-1.
- Per-frame latching: len and LSB_FIRST are latched at frame start and held for the whole frame. Changes mid-frame take effect from the next frame.
- FSM, two states:
  - IDLE: at an edge where SSPFSSIN=1 and RX_ENABLE=1, go to SHIFT, bit counter = len-1, shift register cleared. The data bit for that edge is not sampled.
  - SHIFT: each edge samples SSPRXD.
    - MSB-first: the first bit lands in bit len-1, the last in bit 0.
    - LSB-first: the first bit lands in bit 0, the last in bit len-1.
    - Bits at len and above are 0.
    - The counter decrements every edge. SSPFSSIN is ignored until the last bit; there is no resync.
  - Last bit (counter=0):
    - The assembled word is pushed at that same edge.
    - receive_signal=1 for the following cycle.
    - If SSPFSSIN=1 at that edge and RX_ENABLE=1: stay in SHIFT and re-latch len/LSB_FIRST (back-to-back frames, zero gap).
    - Otherwise go to IDLE.
  - RX_ENABLE deasserted mid-frame: the current frame still completes.
- FIFO:
  - First-word fall-through. RxData = mem[rd_ptr] while not empty, 0 when empty.
  - A pushed word is visible on RxData/RX_NOT_EMPTY in the cycle after the last-bit edge.
  - Pop when empty is ignored; pointers and level are unchanged.
  - Push when full and no pop in the same cycle: word dropped, RX_OVERRUN set; receive_signal still pulses.
  - Push and pop in the same cycle, including when full: both occur, level unchanged, no overrun.
  - Pointers wrap modulo DEPTH.
  - RX_LEVEL = writes minus reads; RX_FULL = (RX_LEVEL==DEPTH).
- RX_OVERRUN: cleared by OVR_CLR. If a set and OVR_CLR occur in the same cycle, set wins.

Test Plan:
1. DSS=7, LSB_FIRST=0, SSPFSSIN pulsed 1 cycle, bits 1,0,1,0,0,1,0,1 -> receive_signal pulses once; RxData=0x00A5, RX_LEVEL=1; one RX_RD -> RX_NOT_EMPTY=0.
2. DSS=3, SSPFSSIN held high for 12 bit times, bits 1100 0011 1010 -> three back-to-back words 0xC, 0x3, 0xA with no gap cycles; RX_LEVEL=3.
3. DSS=15, LSB_FIRST=1, serial bits of 0x1234 LSB first -> RxData=0x1234. A repeat with DSS=1 (clamped to 4-bit frames) and bits 1,0,1,1 with LSB_FIRST=0 -> RxData=0x000B.
4. DEPTH=4, five 8-bit frames 0x01..0x05 with no reads -> RX_FULL=1, RX_OVERRUN=1; reads return 0x01..0x04; OVR_CLR -> RX_OVERRUN=0.
5. FIFO full, RX_RD asserted on the last-bit edge of frame 0x66 -> RX_LEVEL stays 4, no overrun; the last word read is 0x66.
6. CLEAR pulsed after 3 of 8 bits, then a clean frame 0x5A -> all outputs 0 during reset; only 0x5A is received, RX_LEVEL=1.
